// File: rtl/second_player_ctrl.sv
// Second-player fighter controller: position, health, stun and regen
// tracking for one player on a three-cell board, updated on round ticks.
module second_player_ctrl #(
    parameter int STUN_CYCLES = 2,
    parameter int REGEN_WAITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       act_en,
    input  logic [2:0] action2,
    input  logic [2:0] action1,
    input  logic [2:0] state1,
    output logic [2:0] state2,
    output logic [1:0] health,
    output logic       alive,
    output logic       hit,
    output logic       stunned
);

    localparam int SW = (STUN_CYCLES < 1) ? 1 : $clog2(STUN_CYCLES + 1);
    localparam int WW = (REGEN_WAITS < 2) ? 1 : $clog2(REGEN_WAITS);

    localparam logic [2:0] A_KICK   = 3'b000;
    localparam logic [2:0] A_PUNCH  = 3'b001;
    localparam logic [2:0] A_AWAIT  = 3'b010;
    localparam logic [2:0] A_JUMP   = 3'b011;

    typedef enum logic [1:0] {
        P_R,
        P_M,
        P_L,
        KO
    } pos_e;

    pos_e            state_q, state_d;
    logic [2:0]      cell_q, cell_d;
    logic [1:0]      health_q, health_d;
    logic            hit_q, hit_d;
    logic [SW-1:0]   stun_q, stun_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            arm_q;

    logic [1:0]      own_idx, opp_idx, dmg;
    logic            opp_vld, near, dist1;
    logic            kick_dmg, punch_dmg, push;
    logic            go_left, go_right;

    // Board indices (0 = left .. 2 = right) and attack reach
    always_comb begin
        own_idx = 2'd2;
        opp_idx = 2'd0;
        opp_vld = 1'b1;
        case (state_q)
            P_L:     own_idx = 2'd0;
            P_M:     own_idx = 2'd1;
            default: own_idx = 2'd2;
        endcase
        if (state_q == KO) begin
            case (cell_q)
                3'b100:  own_idx = 2'd0;
                3'b010:  own_idx = 2'd1;
                default: own_idx = 2'd2;
            endcase
        end
        case (state1)
            3'b100:  opp_idx = 2'd0;
            3'b010:  opp_idx = 2'd1;
            3'b001:  opp_idx = 2'd2;
            default: opp_vld = 1'b0;
        endcase
        dist1 = opp_vld &&
                ((own_idx == opp_idx + 2'd1) || (opp_idx == own_idx + 2'd1));
        near  = dist1 || (opp_vld && (own_idx == opp_idx));
        kick_dmg  = near && (action1 == A_KICK) && (action2 != A_JUMP);
        punch_dmg = near && (action1 == A_PUNCH) && (action2 != A_PUNCH);
        push      = kick_dmg && dist1 && (action2 == A_KICK);
        dmg       = punch_dmg ? 2'd2 : 2'd1;
        go_left   = (action2[2:1] == 2'b10);
        go_right  = (action2[2:1] == 2'b11);
    end

    // Next-state: damage wins over movement and regen on the same tick
    always_comb begin
        state_d  = state_q;
        health_d = health_q;
        hit_d    = 1'b0;
        stun_d   = stun_q;
        wait_d   = wait_q;
        if (arm_q && act_en && (state_q != KO)) begin
            if (kick_dmg || punch_dmg) begin
                hit_d    = 1'b1;
                stun_d   = SW'(STUN_CYCLES);
                wait_d   = '0;
                health_d = (health_q > dmg) ? health_q - dmg : 2'd0;
                if (push && (state_q == P_L)) state_d = P_M;
                if (push && (state_q == P_M)) state_d = P_R;
                if (health_d == 2'd0) state_d = KO;
            end else begin
                if (stun_q != '0) stun_d = stun_q - SW'(1);
                if (stun_q == '0) begin
                    case (state_q)
                        P_R: begin
                            if (go_left && state1 != 3'b010) state_d = P_M;
                        end
                        P_M: begin
                            if (go_left && state1 != 3'b100) state_d = P_L;
                            if (go_right && state1 != 3'b001) state_d = P_R;
                        end
                        P_L: begin
                            if (go_right && state1 != 3'b010) state_d = P_M;
                        end
                        default: state_d = state_q;
                    endcase
                end
                if (action2 == A_AWAIT) begin
                    if (wait_q >= WW'(REGEN_WAITS - 1)) begin
                        wait_d = '0;
                        if (health_q != 2'd3) health_d = health_q + 2'd1;
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end else begin
                    wait_d = '0;
                end
            end
        end
        case (state_d)
            P_R:     cell_d = 3'b001;
            P_M:     cell_d = 3'b010;
            P_L:     cell_d = 3'b100;
            default: cell_d = cell_q;
        endcase
    end

    // State registers; arm_q swallows the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= P_R;
            cell_q   <= 3'b001;
            health_q <= 2'd3;
            hit_q    <= 1'b0;
            stun_q   <= '0;
            wait_q   <= '0;
            arm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cell_q   <= cell_d;
            health_q <= health_d;
            hit_q    <= hit_d;
            stun_q   <= stun_d;
            wait_q   <= wait_d;
            arm_q    <= 1'b1;
        end
    end

    assign state2  = cell_q;
    assign health  = health_q;
    assign alive   = (health_q != 2'd0);
    assign hit     = hit_q;
    assign stunned = (stun_q != '0);

endmodule

// File: tb/tb_second_player_ctrl.sv
// Bench for second_player_ctrl: directed vector table, async reset
// sequence, then random ticks against an integer board model.
module tb_second_player_ctrl;

    localparam int STUN  = 2;
    localparam int REGEN = 2;

    localparam logic [2:0] KICK   = 3'b000;
    localparam logic [2:0] PUNCH  = 3'b001;
    localparam logic [2:0] AWAIT  = 3'b010;
    localparam logic [2:0] JUMP   = 3'b011;
    localparam logic [2:0] LEFT1  = 3'b100;
    localparam logic [2:0] LEFT2  = 3'b101;
    localparam logic [2:0] RIGHT1 = 3'b110;
    localparam logic [2:0] RIGHT2 = 3'b111;
    localparam logic [2:0] CL     = 3'b100;
    localparam logic [2:0] CM     = 3'b010;
    localparam logic [2:0] CR     = 3'b001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       act_en = 1'b0;
    logic [2:0] action2 = AWAIT;
    logic [2:0] action1 = AWAIT;
    logic [2:0] state1 = CL;
    logic [2:0] state2;
    logic [1:0] health;
    logic       alive, hit, stunned;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic       en;
        logic [2:0] a2, a1, s1;
        logic [2:0] st;
        logic [1:0] hp;
        logic       al, ht, sn;
    } vec_t;

    vec_t tbl[$];

    int m_pos, m_hp, m_stun, m_wait, m_hit;
    bit m_ko;

    second_player_ctrl #(.STUN_CYCLES(STUN), .REGEN_WAITS(REGEN)) dut (
        .clk(clk), .rst_n(rst_n), .act_en(act_en),
        .action2(action2), .action1(action1), .state1(state1),
        .state2(state2), .health(health), .alive(alive),
        .hit(hit), .stunned(stunned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st,
                           input logic [1:0] hp, input logic al,
                           input logic ht, input logic sn);
        chk({tag, " state2"}, 8'(state2), 8'(st));
        chk({tag, " health"}, 8'(health), 8'(hp));
        chk({tag, " alive"}, 8'(alive), 8'(al));
        chk({tag, " hit"}, 8'(hit), 8'(ht));
        chk({tag, " stunned"}, 8'(stunned), 8'(sn));
    endtask

    function automatic vec_t mk(input logic en, input logic [2:0] a2,
                                input logic [2:0] a1, input logic [2:0] s1,
                                input logic [2:0] st, input logic [1:0] hp,
                                input logic al, input logic ht,
                                input logic sn);
        vec_t v;
        v.en = en; v.a2 = a2; v.a1 = a1; v.s1 = s1;
        v.st = st; v.hp = hp; v.al = al; v.ht = ht; v.sn = sn;
        return v;
    endfunction

    task automatic apply(input logic en, input logic [2:0] a2,
                         input logic [2:0] a1, input logic [2:0] s1);
        @(negedge clk);
        act_en = en; action2 = a2; action1 = a1; state1 = s1;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pos = 2; m_hp = 3; m_stun = 0; m_wait = 0; m_hit = 0; m_ko = 0;
    endtask

    function automatic logic [2:0] model_cell();
        logic [2:0] c;
        c = 3'b100;
        return c >> m_pos;
    endfunction

    task automatic model_step(input logic en, input logic [2:0] a2,
                              input logic [2:0] a1, input logic [2:0] s1);
        int o, d, dmg;
        bit was_stun;
        m_hit = 0;
        if (!en || m_ko) return;
        o = (s1 == CL) ? 0 : (s1 == CM) ? 1 : 2;
        d = (m_pos > o) ? m_pos - o : o - m_pos;
        dmg = 0;
        if (d <= 1) begin
            if (a1 == KICK && a2 != JUMP) dmg = 1;
            else if (a1 == PUNCH && a2 != PUNCH) dmg = 2;
        end
        if (dmg > 0) begin
            m_hit = 1;
            m_stun = STUN;
            m_wait = 0;
            m_hp = (m_hp > dmg) ? m_hp - dmg : 0;
            if (a1 == KICK && a2 == KICK && d == 1 && m_pos < 2) m_pos++;
            if (m_hp == 0) m_ko = 1;
        end else begin
            was_stun = (m_stun > 0);
            if (was_stun) m_stun--;
            if (!was_stun) begin
                if ((a2 == LEFT1 || a2 == LEFT2) && m_pos > 0 && m_pos - 1 != o)
                    m_pos--;
                else if ((a2 == RIGHT1 || a2 == RIGHT2) && m_pos < 2 &&
                         m_pos + 1 != o)
                    m_pos++;
            end
            if (a2 == AWAIT) begin
                m_wait++;
                if (m_wait >= REGEN) begin
                    m_wait = 0;
                    if (m_hp < 3) m_hp++;
                end
            end else begin
                m_wait = 0;
            end
        end
    endtask

    task automatic do_reset(input string tag);
        act_en = 1'b1; action2 = LEFT1; action1 = AWAIT; state1 = CL;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all({tag, " in-reset"}, CR, 2'd3, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all({tag, " first-edge"}, CR, 2'd3, 1'b1, 1'b0, 1'b0);
        model_reset();
    endtask

    initial begin
        logic en;
        logic [2:0] a2, a1, s1, c;

        tbl.push_back(mk(1, LEFT1, AWAIT, CL, CM, 3, 1, 0, 0));
        tbl.push_back(mk(1, LEFT1, AWAIT, CL, CM, 3, 1, 0, 0));
        tbl.push_back(mk(1, LEFT2, AWAIT, CL, CM, 3, 1, 0, 0));
        tbl.push_back(mk(1, JUMP, KICK, CL, CM, 3, 1, 0, 0));
        tbl.push_back(mk(1, AWAIT, KICK, CL, CM, 2, 1, 1, 1));
        tbl.push_back(mk(1, AWAIT, AWAIT, CL, CM, 2, 1, 0, 1));
        tbl.push_back(mk(1, AWAIT, AWAIT, CL, CM, 3, 1, 0, 0));
        tbl.push_back(mk(1, AWAIT, KICK, CL, CM, 2, 1, 1, 1));
        tbl.push_back(mk(1, RIGHT1, AWAIT, CL, CM, 2, 1, 0, 1));
        tbl.push_back(mk(1, RIGHT2, AWAIT, CL, CM, 2, 1, 0, 0));
        tbl.push_back(mk(1, RIGHT1, AWAIT, CL, CR, 2, 1, 0, 0));
        tbl.push_back(mk(1, AWAIT, AWAIT, CL, CR, 2, 1, 0, 0));
        tbl.push_back(mk(1, KICK, AWAIT, CL, CR, 2, 1, 0, 0));
        tbl.push_back(mk(1, AWAIT, AWAIT, CL, CR, 2, 1, 0, 0));
        tbl.push_back(mk(1, AWAIT, AWAIT, CL, CR, 3, 1, 0, 0));
        tbl.push_back(mk(1, AWAIT, AWAIT, CL, CR, 3, 1, 0, 0));
        tbl.push_back(mk(1, AWAIT, AWAIT, CL, CR, 3, 1, 0, 0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, AWAIT, PUNCH, CM, CR, 3, 1, 0, 0));
        tbl.push_back(mk(1, LEFT1, AWAIT, CL, CM, 3, 1, 0, 0));
        tbl.push_back(mk(1, KICK, KICK, CL, CR, 2, 1, 1, 1));
        tbl.push_back(mk(1, PUNCH, PUNCH, CM, CR, 2, 1, 0, 1));
        tbl.push_back(mk(1, AWAIT, KICK, CM, CR, 1, 1, 1, 1));
        tbl.push_back(mk(1, KICK, PUNCH, CM, CR, 0, 0, 1, 1));
        tbl.push_back(mk(1, RIGHT1, AWAIT, CM, CR, 0, 0, 0, 1));
        tbl.push_back(mk(1, AWAIT, KICK, CM, CR, 0, 0, 0, 1));
        tbl.push_back(mk(1, AWAIT, AWAIT, CM, CR, 0, 0, 0, 1));
        tbl.push_back(mk(1, LEFT1, PUNCH, CM, CR, 0, 0, 0, 1));

        do_reset("r0");
        foreach (tbl[i]) begin
            apply(tbl[i].en, tbl[i].a2, tbl[i].a1, tbl[i].s1);
            chk_all($sformatf("v%0d", i), tbl[i].st, tbl[i].hp,
                    tbl[i].al, tbl[i].ht, tbl[i].sn);
        end

        do_reset("r1");
        apply(1, LEFT1, AWAIT, CL);
        chk_all("mid move", CM, 3, 1, 0, 0);
        apply(1, AWAIT, KICK, CL);
        chk_all("mid hit", CM, 2, 1, 1, 1);
        act_en = 1'b1; action2 = LEFT1; action1 = KICK;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async rst", CR, 3, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("rst release edge", CR, 3, 1, 0, 0);
        apply(1, LEFT1, AWAIT, CL);
        chk_all("after rst move", CM, 3, 1, 0, 0);

        for (int blk = 0; blk < 5; blk++) begin
            do_reset($sformatf("rb%0d", blk));
            for (int t = 0; t < 80; t++) begin
                en = ($urandom_range(0, 4) != 0);
                a2 = 3'($urandom_range(0, 7));
                a1 = 3'($urandom_range(0, 7));
                c = 3'b100;
                s1 = c >> $urandom_range(0, 2);
                apply(en, a2, a1, s1);
                model_step(en, a2, a1, s1);
                chk_all($sformatf("rnd b%0d t%0d", blk, t), model_cell(),
                        2'(m_hp), (m_hp != 0), m_hit[0], (m_stun > 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
